maxpool2d: RTL

2-D max-pooling stage sitting directly downstream of the parallel convolution block. It snapshots the convolution output matrix when the convolution pulses `done`. It then scans it with a non-overlapping POOL×POOL window, one output element per clock. It presents the pooled matrix with its own one-cycle `done` pulse for the next layer.

---
 rtl/maxpool2d_pkg.sv | 7 +
 rtl/maxpool2d_max_window.sv | 15 +
 rtl/maxpool2d.sv | 71 +++++++
 3 files changed

// File: rtl/maxpool2d_pkg.sv
// cnn_pkg: shared types and helpers for the CNN pooling stage.
package cnn_pkg;
  typedef enum logic {IDLE, SCAN} pool_state_t;
  function automatic int out_side(input int size, input int pool);
    return size / pool;
  endfunction
endpackage

// File: rtl/maxpool2d_max_window.sv
// max_window: signed maximum of one POOLxPOOL window, purely combinational.
module max_window #(
  parameter int POOL = 2,
  parameter int WIDTH_BIT = 8
) (
  input  logic signed [WIDTH_BIT-1:0] win [POOL-1:0][POOL-1:0],
  output logic signed [WIDTH_BIT-1:0] max_out
);
  always_comb begin
    max_out = win[0][0];
    for (int a = 0; a < POOL; a++)
      for (int b = 0; b < POOL; b++)
        max_out = (win[a][b] > max_out) ? win[a][b] : max_out;
  end
endmodule

// File: rtl/maxpool2d.sv
// maxpool2d: snapshots the conv output and writes one pooled element per clock.
module maxpool2d
  import cnn_pkg::*;
#(
  parameter int SIZE = 6,
  parameter int POOL = 2,
  parameter int WIDTH_BIT = 8,
  localparam int OSIZE = out_side(SIZE, POOL)
) (
  input  logic clock,
  input  logic nreset,
  input  logic start,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE-1:0][SIZE-1:0],
  output logic signed [WIDTH_BIT-1:0] poolOut [OSIZE-1:0][OSIZE-1:0],
  output logic busy,
  output logic done
);
  localparam int CW = (OSIZE > 1) ? $clog2(OSIZE) : 1;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  pool_state_t state;
  logic [CW-1:0] r, c;
  logic signed [WIDTH_BIT-1:0] snap [SIZE-1:0][SIZE-1:0];
  logic signed [WIDTH_BIT-1:0] win [POOL-1:0][POOL-1:0];
  logic signed [WIDTH_BIT-1:0] max_out;
  logic [IW-1:0] row_base, col_base;
  assign row_base = IW'(int'(r) * POOL);
  assign col_base = IW'(int'(c) * POOL);
  always_comb
    for (int a = 0; a < POOL; a++)
      for (int b = 0; b < POOL; b++)
        win[a][b] = snap[row_base + IW'(a)][col_base + IW'(b)];
  max_window #(.POOL(POOL), .WIDTH_BIT(WIDTH_BIT)) u_max (
    .win(win),
    .max_out(max_out)
  );
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      snap <= '{default: '0};
      poolOut <= '{default: '0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap <= inpMatrixI;
          r <= '0;
          c <= '0;
          busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          poolOut[r][c] <= max_out;
          if (c == CW'(OSIZE - 1)) begin
            c <= '0;
            if (r == CW'(OSIZE - 1)) begin
              r <= '0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= IDLE;
            end else r <= r + 1'b1;
          end else c <= c + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
